// File: rtl/neuron_load_ctrl.sv
// ============================================================================
// neuron_load_ctrl : sequences host words into neuron Q/Vmem/neuronI/mu
// registers, then enables spiking until the network reports completion.
// Revision 1.0
// ============================================================================
`default_nettype none

module neuron_load_ctrl #(
    parameter int MU_DATA_WIDTH    = 16,
    parameter int VMEM_DATA_WIDTH  = 16,
    parameter int Q_DATA_WIDTH     = 2,
    parameter int SPIKE_ADDR_WIDTH = 10,
    parameter int N_Q              = 64,
    parameter int N_VMEM           = 1,
    parameter int N_NEURONI        = 1,
    parameter int N_MU             = 1,
    parameter int CNT_WIDTH        = 12
) (
    input  logic                        clk,
    input  logic                        reset_l,
    input  logic                        start,
    input  logic                        abort,
    input  logic [15:0]                 host_data,
    input  logic                        host_valid,
    output logic                        host_ready,
    output logic                        wrQ,
    output logic                        wrVmem,
    output logic                        wrNeuronI,
    output logic                        wrMu,
    output logic [Q_DATA_WIDTH-1:0]     Q_in,
    output logic [VMEM_DATA_WIDTH-1:0]  Vmem_in,
    output logic [SPIKE_ADDR_WIDTH-1:0] neuronI_in,
    output logic [MU_DATA_WIDTH-1:0]    mu_in,
    output logic                        en_neuron,
    output logic                        en_spike,
    input  logic                        networkDone,
    output logic                        busy,
    output logic                        done,
    output logic [2:0]                  state_o
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_LD_Q    = 3'd1;
    localparam logic [2:0] c_LD_VMEM = 3'd2;
    localparam logic [2:0] c_LD_NI   = 3'd3;
    localparam logic [2:0] c_LD_MU   = 3'd4;
    localparam logic [2:0] c_RUN     = 3'd5;
    localparam logic [2:0] c_DONE    = 3'd6;

    // Successor of each phase, skipping phases configured with zero words.
    localparam logic [2:0] c_AFTER_MU   = c_RUN;
    localparam logic [2:0] c_AFTER_NI   = (N_MU != 0)      ? c_LD_MU   : c_AFTER_MU;
    localparam logic [2:0] c_AFTER_VMEM = (N_NEURONI != 0) ? c_LD_NI   : c_AFTER_NI;
    localparam logic [2:0] c_AFTER_Q    = (N_VMEM != 0)    ? c_LD_VMEM : c_AFTER_VMEM;
    localparam logic [2:0] c_FIRST      = (N_Q != 0)       ? c_LD_Q    : c_AFTER_Q;

    localparam logic [CNT_WIDTH-1:0] c_LAST_Q    = CNT_WIDTH'(N_Q - 1);
    localparam logic [CNT_WIDTH-1:0] c_LAST_VMEM = CNT_WIDTH'(N_VMEM - 1);
    localparam logic [CNT_WIDTH-1:0] c_LAST_NI   = CNT_WIDTH'(N_NEURONI - 1);
    localparam logic [CNT_WIDTH-1:0] c_LAST_MU   = CNT_WIDTH'(N_MU - 1);

    logic [2:0]                  r_state;
    logic [2:0]                  w_next;
    logic [CNT_WIDTH-1:0]        r_cnt;
    logic [CNT_WIDTH-1:0]        w_cnt_next;
    logic                        w_in_load;
    logic                        w_accept;
    logic                        w_last;
    logic [2:0]                  w_after;

    logic                        r_wrQ;
    logic                        r_wrVmem;
    logic                        r_wrNeuronI;
    logic                        r_wrMu;
    logic [Q_DATA_WIDTH-1:0]     r_Q_in;
    logic [VMEM_DATA_WIDTH-1:0]  r_Vmem_in;
    logic [SPIKE_ADDR_WIDTH-1:0] r_neuronI_in;
    logic [MU_DATA_WIDTH-1:0]    r_mu_in;
    logic                        r_en_neuron;
    logic                        r_en_spike;
    logic                        r_busy;
    logic                        r_done;

    assign w_in_load  = (r_state >= c_LD_Q) && (r_state <= c_LD_MU);
    assign host_ready = w_in_load && !abort;
    assign w_accept   = host_valid && host_ready;

    always_comb begin
        w_last  = 1'b0;
        w_after = c_RUN;
        case (r_state)
            c_LD_Q:    begin w_last = (r_cnt == c_LAST_Q);    w_after = c_AFTER_Q;    end
            c_LD_VMEM: begin w_last = (r_cnt == c_LAST_VMEM); w_after = c_AFTER_VMEM; end
            c_LD_NI:   begin w_last = (r_cnt == c_LAST_NI);   w_after = c_AFTER_NI;   end
            c_LD_MU:   begin w_last = (r_cnt == c_LAST_MU);   w_after = c_AFTER_MU;   end
            default:   begin w_last = 1'b0;                   w_after = c_RUN;        end
        endcase
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        if (abort) begin
            w_next     = c_IDLE;
            w_cnt_next = '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        w_next     = c_FIRST;
                        w_cnt_next = '0;
                    end
                end
                c_LD_Q, c_LD_VMEM, c_LD_NI, c_LD_MU: begin
                    if (w_accept) begin
                        if (w_last) begin
                            w_next     = w_after;
                            w_cnt_next = '0;
                        end else begin
                            w_cnt_next = r_cnt + CNT_WIDTH'(1);
                        end
                    end
                end
                c_RUN:   if (networkDone) w_next = c_DONE;
                c_DONE:  w_next = c_IDLE;
                default: w_next = c_IDLE;
            endcase
        end
    end

    // Status outputs are decoded from the next state so they line up with state_o.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state      <= c_IDLE;
            r_cnt        <= '0;
            r_wrQ        <= 1'b0;
            r_wrVmem     <= 1'b0;
            r_wrNeuronI  <= 1'b0;
            r_wrMu       <= 1'b0;
            r_Q_in       <= '0;
            r_Vmem_in    <= '0;
            r_neuronI_in <= '0;
            r_mu_in      <= '0;
            r_en_neuron  <= 1'b0;
            r_en_spike   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_next;
            r_wrQ       <= w_accept && (r_state == c_LD_Q);
            r_wrVmem    <= w_accept && (r_state == c_LD_VMEM);
            r_wrNeuronI <= w_accept && (r_state == c_LD_NI);
            r_wrMu      <= w_accept && (r_state == c_LD_MU);
            if (w_accept && (r_state == c_LD_Q))    r_Q_in       <= host_data[Q_DATA_WIDTH-1:0];
            if (w_accept && (r_state == c_LD_VMEM)) r_Vmem_in    <= host_data[VMEM_DATA_WIDTH-1:0];
            if (w_accept && (r_state == c_LD_NI))   r_neuronI_in <= host_data[SPIKE_ADDR_WIDTH-1:0];
            if (w_accept && (r_state == c_LD_MU))   r_mu_in      <= host_data[MU_DATA_WIDTH-1:0];
            r_en_neuron <= (w_next >= c_LD_Q) && (w_next <= c_RUN);
            r_en_spike  <= (w_next == c_RUN);
            r_busy      <= (w_next != c_IDLE);
            r_done      <= (w_next == c_DONE);
        end
    end

    assign state_o    = r_state;
    assign wrQ        = r_wrQ;
    assign wrVmem     = r_wrVmem;
    assign wrNeuronI  = r_wrNeuronI;
    assign wrMu       = r_wrMu;
    assign Q_in       = r_Q_in;
    assign Vmem_in    = r_Vmem_in;
    assign neuronI_in = r_neuronI_in;
    assign mu_in      = r_mu_in;
    assign en_neuron  = r_en_neuron;
    assign en_spike   = r_en_spike;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

`default_nettype wire
